// File: rtl/booth_r4_mac_if.sv
// Operand/result bundle for the radix-4 Booth multiply-accumulate unit.
// The master side issues operations; the slave side is the multiplier.
interface booth_r4_mac_if #(
    parameter int pN = 2
);
    localparam int N = 2 ** pN;

    logic           Ld;
    logic           Sgn;
    logic           Acc;
    logic [N-1:0]   M;
    logic [N-1:0]   Q;
    logic           Ready;
    logic           Valid;
    logic [2*N-1:0] Product;

    modport master (
        output Ld, Sgn, Acc, M, Q,
        input  Ready, Valid, Product
    );

    modport slave (
        input  Ld, Sgn, Acc, M, Q,
        output Ready, Valid, Product
    );
endinterface

// File: rtl/booth_r4_mac.sv
// Radix-4 Booth sequential multiplier with optional accumulate into the held
// product. Two multiplier bits retire per cycle; signed/unsigned per operation.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for Ld, Ready = 1
// RUN   | one Booth triplet per cycle, counter 0..ITER-1, Ready = 0
// DONE  | Product just written, Valid = 1, Ready = 1 (Ld here starts next op)
module booth_r4_mac #(
    parameter int pN = 2
) (
    input  logic           Clk,
    input  logic           Rst,
    booth_r4_mac_if.slave  bus
);
    localparam int N    = 2 ** pN;
    localparam int W    = N + 2;          // extended operand width
    localparam int AW   = W + 2;          // accumulator width, holds +-2M sums exactly
    localparam int ITER = W / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   m_reg;
    logic [W-1:0]   q_reg;
    logic           q_m1;
    logic [AW-1:0]  acc_reg;
    logic           acc_mode;
    logic [2*N-1:0] product;

    logic           accept;
    logic           last;
    logic [W-1:0]   m_ext;
    logic [W-1:0]   q_ext;
    logic [AW-1:0]  m_aw;
    logic [AW-1:0]  pp;
    logic [AW-1:0]  sum;
    logic [AW-1:0]  acc_nxt;
    logic [W-1:0]   q_nxt;
    logic [2*N-1:0] res_lo;

    assign accept = bus.Ld && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(ITER - 1));

    // Unsigned operands get two zero bits on top so the signed Booth recoding
    // still sees them as positive.
    assign m_ext = bus.Sgn ? {{2{bus.M[N-1]}}, bus.M} : {2'b00, bus.M};
    assign q_ext = bus.Sgn ? {{2{bus.Q[N-1]}}, bus.Q} : {2'b00, bus.Q};

    assign bus.Ready   = (state != RUN);
    assign bus.Valid   = (state == DONE);
    assign bus.Product = product;

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.Ld) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.Ld ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth recode of the current triplet, add, then arithmetic shift by two.
    always_comb begin
        m_aw = {{2{m_reg[W-1]}}, m_reg};
        pp   = '0;
        unique case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: pp = m_aw;
            3'b011:         pp = m_aw << 1;
            3'b100:         pp = -(m_aw << 1);
            3'b101, 3'b110: pp = -m_aw;
            default:        pp = '0;
        endcase
        sum     = acc_reg + pp;
        acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_nxt   = {sum[1:0], q_reg[W-1:2]};
        // Low 2N bits of the final {acc, q} pair are exact for both operand kinds.
        res_lo  = (2*N)'({acc_nxt, q_nxt});
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt      <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            q_m1     <= 1'b0;
            acc_reg  <= '0;
            acc_mode <= 1'b0;
            product  <= '0;
        end else if (accept) begin
            cnt      <= '0;
            m_reg    <= m_ext;
            q_reg    <= q_ext;
            q_m1     <= 1'b0;
            acc_reg  <= '0;
            acc_mode <= bus.Acc;
        end else if (state == RUN) begin
            acc_reg <= acc_nxt;
            q_reg   <= q_nxt;
            q_m1    <= q_reg[1];
            cnt     <= last ? '0 : cnt + CW'(1);
            if (last) begin
                product <= acc_mode ? (product + res_lo) : res_lo;
            end
        end
    end
endmodule
